// File: rtl/conv_seq_ctrl_if.sv
// Control/status bundle between a job master and the systolic-array sequencer.
// The master drives job requests and stalls; the sequencer drives array enables.
interface conv_seq_ctrl_if #(
  parameter int COLS   = 32,
  parameter int DIM_W  = 5,
  parameter int VEC_W  = 8,
  parameter int TILE_W = 8
);
  logic              start;
  logic              hold;
  logic [DIM_W-1:0]  weight_dim;
  logic [VEC_W-1:0]  num_vec;
  logic [TILE_W-1:0] num_tiles;
  logic              busy;
  logic              w_ps;
  logic              w_load_en;
  logic              feed_en;
  logic [COLS-1:0]   out_en;
  logic              tile_done;
  logic              conv_finish;
  logic              cfg_err;

  modport master (
    output start, hold, weight_dim, num_vec, num_tiles,
    input  busy, w_ps, w_load_en, feed_en, out_en, tile_done, conv_finish, cfg_err
  );

  modport slave (
    input  start, hold, weight_dim, num_vec, num_tiles,
    output busy, w_ps, w_load_en, feed_en, out_en, tile_done, conv_finish, cfg_err
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Multi-tile sequencer for a weight-stationary systolic array: weight load,
// vector feed, column-skewed output enables and drain, with stall support.
module conv_seq_ctrl #(
  parameter int COLS   = 32,
  parameter int DIM_W  = 5,
  parameter int VEC_W  = 8,
  parameter int TILE_W = 8
) (
  input  logic           clk,
  input  logic           nrst,
  conv_seq_ctrl_if.slave bus
);

  // Phase counter must reach K+COLS+N with K and N at their maximum.
  localparam int T_W = $clog2((1 << DIM_W) + COLS + (1 << VEC_W));

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_W,
    S_FEED,
    S_DRAIN
  } state_t;

  state_t            r_state;
  logic [T_W-1:0]    r_t;
  logic [TILE_W-1:0] r_tile;
  logic [DIM_W-1:0]  r_k;
  logic [VEC_W-1:0]  r_n;
  logic [TILE_W-1:0] r_tiles;

  logic              r_busy;
  logic              r_w_ps;
  logic              r_w_load_en;
  logic              r_feed_en;
  logic [COLS-1:0]   r_out_en;
  logic              r_tile_done;
  logic              r_conv_finish;
  logic              r_cfg_err;

  state_t            w_nxt_state;
  logic [T_W-1:0]    w_nxt_t;
  logic [TILE_W-1:0] w_nxt_tile;
  logic              w_stall;
  logic              w_launch;
  logic              w_cfg_bad;
  logic              w_tile_end;
  logic              w_job_end;
  logic [T_W-1:0]    w_last_t;
  logic [T_W:0]      w_k_ext;
  logic [T_W:0]      w_n_ext;
  logic [T_W:0]      w_t_ext;
  logic [COLS-1:0]   w_out_en;

  assign w_cfg_bad = (bus.weight_dim == '0) || (bus.num_vec == '0) || (bus.num_tiles == '0);
  assign w_stall   = bus.hold && (r_state != S_IDLE);
  assign w_last_t  = T_W'(r_k) + T_W'(COLS) + T_W'(r_n) - T_W'(2);
  assign w_k_ext   = (T_W+1)'(r_k);
  assign w_n_ext   = (T_W+1)'(r_n);
  assign w_t_ext   = {1'b0, w_nxt_t};

  // Next position in the sequence; a stall simply leaves it where it is.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    w_nxt_state = r_state;
    w_nxt_t     = r_t;
    w_nxt_tile  = r_tile;
    w_launch    = 1'b0;
    w_tile_end  = 1'b0;
    w_job_end   = 1'b0;
    if (!w_stall) begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start && !w_cfg_bad) begin
            w_launch    = 1'b1;
            w_nxt_state = S_LOAD_W;
            w_nxt_t     = '0;
            w_nxt_tile  = '0;
          end
        end
        S_LOAD_W: begin
          if (r_t == T_W'(r_k) - T_W'(1)) begin
            w_nxt_state = S_FEED;
            w_nxt_t     = '0;
          end else begin
            w_nxt_t = r_t + T_W'(1);
          end
        end
        S_FEED, S_DRAIN: begin
          if (r_t == w_last_t) begin
            w_tile_end = 1'b1;
            w_nxt_t    = '0;
            if (r_tile == r_tiles - TILE_W'(1)) begin
              w_job_end   = 1'b1;
              w_nxt_state = S_IDLE;
            end else begin
              w_nxt_state = S_LOAD_W;
              w_nxt_tile  = r_tile + TILE_W'(1);
            end
          end else begin
            w_nxt_t = r_t + T_W'(1);
            if ((r_state == S_FEED) && (r_t == T_W'(r_n) - T_W'(1))) begin
              w_nxt_state = S_DRAIN;
            end
          end
        end
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  // Column c sees the first result K+c cycles into the feed phase, for N cycles.
  always_comb begin
    w_out_en = '0;
    if (!w_stall && ((w_nxt_state == S_FEED) || (w_nxt_state == S_DRAIN))) begin
      for (int c = 0; c < COLS; c++) begin
        w_out_en[c] = (w_t_ext >= w_k_ext + (T_W+1)'(c)) &&
                      (w_t_ext <  w_k_ext + w_n_ext + (T_W+1)'(c));
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state       <= S_IDLE;
      r_t           <= '0;
      r_tile        <= '0;
      r_k           <= '0;
      r_n           <= '0;
      r_tiles       <= '0;
      r_busy        <= 1'b0;
      r_w_ps        <= 1'b1;
      r_w_load_en   <= 1'b0;
      r_feed_en     <= 1'b0;
      r_out_en      <= '0;
      r_tile_done   <= 1'b0;
      r_conv_finish <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_nxt_state;
      r_t     <= w_nxt_t;
      r_tile  <= w_nxt_tile;
      if (w_launch) begin
        r_k     <= bus.weight_dim;
        r_n     <= bus.num_vec;
        r_tiles <= bus.num_tiles;
      end
      // Outputs describe the cycle being entered, so they decode the next position.
      r_busy        <= (w_nxt_state != S_IDLE);
      r_w_ps        <= (w_nxt_state == S_IDLE) || (w_nxt_state == S_LOAD_W);
      r_w_load_en   <= !w_stall && (w_nxt_state == S_LOAD_W);
      r_feed_en     <= !w_stall && (w_nxt_state == S_FEED);
      r_out_en      <= w_out_en;
      r_tile_done   <= w_tile_end;
      r_conv_finish <= w_job_end;
      r_cfg_err     <= (r_state == S_IDLE) && bus.start && w_cfg_bad;
    end
  end

  assign bus.busy        = r_busy;
  assign bus.w_ps        = r_w_ps;
  assign bus.w_load_en   = r_w_load_en;
  assign bus.feed_en     = r_feed_en;
  assign bus.out_en      = r_out_en;
  assign bus.tile_done   = r_tile_done;
  assign bus.conv_finish = r_conv_finish;
  assign bus.cfg_err     = r_cfg_err;

endmodule
